// File: rtl/alu_pkg.sv
// Shared widths, ALU opcode encodings and scheduler state type for the
// ALU-sharing scheduler.
package alu_pkg;

   localparam int DATA_W = 16;
   localparam int OP_W   = 3;

   localparam logic [OP_W-1:0] OP_ADD = 3'b000;
   localparam logic [OP_W-1:0] OP_SUB = 3'b001;
   localparam logic [OP_W-1:0] OP_OR  = 3'b010;
   localparam logic [OP_W-1:0] OP_AND = 3'b011;
   localparam logic [OP_W-1:0] OP_XOR = 3'b100;
   localparam logic [OP_W-1:0] OP_NOT = 3'b101;
   localparam logic [OP_W-1:0] OP_SHL = 3'b110;
   localparam logic [OP_W-1:0] OP_SHR = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } sched_state_t;

endpackage

// File: rtl/alu_scheduler_if.sv
// Requester-side request/response handshakes plus the ALU drive/return bus.
// The slave modport is the scheduler's view; master is the surrounding logic.
interface alu_scheduler_if #(
   parameter int NUM_REQ = 4
);
   import alu_pkg::*;

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [DATA_W*NUM_REQ-1:0] req_a;
   logic [DATA_W*NUM_REQ-1:0] req_b;
   logic [OP_W*NUM_REQ-1:0]   req_op;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [NUM_REQ-1:0]        rsp_ready;
   logic [DATA_W-1:0]         rsp_result;
   logic                      rsp_cout;
   logic [DATA_W-1:0]         alu_A;
   logic [DATA_W-1:0]         alu_B;
   logic [OP_W-1:0]           alu_opcode;
   logic                      alu_Enable;
   logic [DATA_W-1:0]         alu_result;
   logic                      alu_Cout;

   modport master (
      output req_valid, req_a, req_b, req_op, rsp_ready, alu_result, alu_Cout,
      input  req_ready, rsp_valid, rsp_result, rsp_cout,
             alu_A, alu_B, alu_opcode, alu_Enable
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op, rsp_ready, alu_result, alu_Cout,
      output req_ready, rsp_valid, rsp_result, rsp_cout,
             alu_A, alu_B, alu_opcode, alu_Enable
   );

endinterface

// File: rtl/alu_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first asserted
// request at or after ptr, searching upward modulo NUM_REQ.
module rr_arbiter #(
   parameter int  NUM_REQ = 4,
   localparam int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic               grant_valid
);

   localparam logic [PTR_W:0] N_W = (PTR_W+1)'(NUM_REQ);

   logic [NUM_REQ-1:0] rot_req;
   logic [NUM_REQ-1:0] rot_first;

   // Rotate so ptr lands at bit 0, isolate the lowest set bit, rotate back.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
         logic [PTR_W:0]   fwd_sum;
         logic [PTR_W:0]   back_sum;
         logic [PTR_W-1:0] fwd_idx;
         logic [PTR_W-1:0] back_idx;

         assign fwd_sum  = {1'b0, ptr} + (PTR_W+1)'(gi);
         assign fwd_idx  = (fwd_sum >= N_W) ? PTR_W'(fwd_sum - N_W) : fwd_sum[PTR_W-1:0];
         assign back_sum = (PTR_W+1)'(gi) + N_W - {1'b0, ptr};
         assign back_idx = (back_sum >= N_W) ? PTR_W'(back_sum - N_W) : back_sum[PTR_W-1:0];

         assign rot_req[gi] = req[fwd_idx];
         assign grant[gi]   = rot_first[back_idx];
      end
   endgenerate

   assign rot_first   = rot_req & (~rot_req + NUM_REQ'(1));
   assign grant_valid = |req;

endmodule

// File: rtl/alu_scheduler.sv
// Shares one registered-latency ALU among NUM_REQ requesters: round-robin
// accept, one-cycle enable pulse, latency wait, held one-hot response.
module alu_scheduler
   import alu_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int ALU_LATENCY = 1
) (
   input logic            clk,
   input logic            rst,
   alu_scheduler_if.slave bus
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(ALU_LATENCY + 1);

   sched_state_t       state_reg;
   logic [PTR_W-1:0]   ptr_reg;
   logic [PTR_W-1:0]   gnt_idx_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic [DATA_W-1:0]  alu_a_reg;
   logic [DATA_W-1:0]  alu_b_reg;
   logic [OP_W-1:0]    alu_op_reg;
   logic               alu_en_reg;
   logic [NUM_REQ-1:0] rsp_valid_reg;
   logic [DATA_W-1:0]  rsp_result_reg;
   logic               rsp_cout_reg;

   logic [NUM_REQ-1:0] grant;
   logic               grant_valid;
   logic [PTR_W-1:0]   grant_idx;
   logic [PTR_W-1:0]   ptr_next;

   logic [DATA_W-1:0]  a_arr  [NUM_REQ];
   logic [DATA_W-1:0]  b_arr  [NUM_REQ];
   logic [OP_W-1:0]    op_arr [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign a_arr[gi]  = bus.req_a[gi*DATA_W +: DATA_W];
         assign b_arr[gi]  = bus.req_b[gi*DATA_W +: DATA_W];
         assign op_arr[gi] = bus.req_op[gi*OP_W +: OP_W];
      end
   endgenerate

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .req         (bus.req_valid),
      .ptr         (ptr_reg),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) grant_idx = PTR_W'(i);
      end
   end

   assign ptr_next = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);

   // Only IDLE may accept; the grant itself is the ready vector.
   assign bus.req_ready = (state_reg == S_IDLE) ? grant : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= S_IDLE;
         ptr_reg        <= '0;
         gnt_idx_reg    <= '0;
         cnt_reg        <= '0;
         alu_a_reg      <= '0;
         alu_b_reg      <= '0;
         alu_op_reg     <= '0;
         alu_en_reg     <= 1'b0;
         rsp_valid_reg  <= '0;
         rsp_result_reg <= '0;
         rsp_cout_reg   <= 1'b0;
      end else begin
         alu_en_reg <= 1'b0;
         unique case (state_reg)
            S_IDLE: begin
               if (grant_valid) begin
                  alu_a_reg   <= a_arr[grant_idx];
                  alu_b_reg   <= b_arr[grant_idx];
                  alu_op_reg  <= op_arr[grant_idx];
                  alu_en_reg  <= 1'b1;
                  gnt_idx_reg <= grant_idx;
                  ptr_reg     <= ptr_next;
                  state_reg   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               cnt_reg   <= CNT_W'(ALU_LATENCY);
               state_reg <= S_WAIT;
            end
            S_WAIT: begin
               cnt_reg <= cnt_reg - CNT_W'(1);
               if (cnt_reg == CNT_W'(1)) begin
                  rsp_result_reg <= bus.alu_result;
                  rsp_cout_reg   <= bus.alu_Cout;
                  rsp_valid_reg  <= NUM_REQ'(1) << gnt_idx_reg;
                  state_reg      <= S_RESP;
               end
            end
            S_RESP: begin
               if (bus.rsp_ready[gnt_idx_reg]) begin
                  rsp_valid_reg <= '0;
                  state_reg     <= S_IDLE;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign bus.alu_A      = alu_a_reg;
   assign bus.alu_B      = alu_b_reg;
   assign bus.alu_opcode = alu_op_reg;
   assign bus.alu_Enable = alu_en_reg;
   assign bus.rsp_valid  = rsp_valid_reg;
   assign bus.rsp_result = rsp_result_reg;
   assign bus.rsp_cout   = rsp_cout_reg;

endmodule

// File: tb/tb_alu_scheduler.sv
// Randomized bench for alu_scheduler: transaction-level reference model of
// round-robin grants, latencies and ALU results, plus a latency-3 instance.
module tb_alu_scheduler;
   import alu_pkg::*;

   localparam int N    = 4;
   localparam int L    = 1;
   localparam int L3   = 3;
   localparam int NCYC = 3000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_scheduler_if #(.NUM_REQ(N)) bus  ();
   alu_scheduler_if #(.NUM_REQ(N)) bus3 ();

   alu_scheduler #(.NUM_REQ(N), .ALU_LATENCY(L))  dut  (.clk(clk), .rst(rst), .bus(bus.slave));
   alu_scheduler #(.NUM_REQ(N), .ALU_LATENCY(L3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [16:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                           input logic [2:0] op);
      case (op)
         OP_ADD:  return {1'b0, a} + {1'b0, b};
         OP_SUB:  return {1'b0, a} - {1'b0, b};
         OP_OR:   return {1'b0, a | b};
         OP_AND:  return {1'b0, a & b};
         OP_XOR:  return {1'b0, a ^ b};
         OP_NOT:  return {1'b0, ~a};
         OP_SHL:  return {a[15], a << 1};
         default: return {a[0], a >> 1};
      endcase
   endfunction

   function automatic int rr_pick(input int p, input logic [N-1:0] v);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   // ALU stand-ins: result appears LATENCY edges after the enable edge,
   // junk on every other cycle so a mistimed capture is visible.
   logic [16:0] pipe1 [L];
   logic [16:0] pipe3 [L3];
   always @(posedge clk) begin
      pipe1[0] <= bus.alu_Enable ? alu_ref(bus.alu_A, bus.alu_B, bus.alu_opcode) : 17'($urandom);
      for (int i = 1; i < L; i++) pipe1[i] <= pipe1[i-1];
      pipe3[0] <= bus3.alu_Enable ? alu_ref(bus3.alu_A, bus3.alu_B, bus3.alu_opcode) : 17'($urandom);
      for (int i = 1; i < L3; i++) pipe3[i] <= pipe3[i-1];
   end
   assign bus.alu_result  = pipe1[L-1][15:0];
   assign bus.alu_Cout    = pipe1[L-1][16];
   assign bus3.alu_result = pipe3[L3-1][15:0];
   assign bus3.alu_Cout   = pipe3[L3-1][16];

   // Requester and model state
   logic [N-1:0] pv;
   logic [15:0]  pa [N];
   logic [15:0]  pb [N];
   logic [2:0]   po [N];
   logic [N-1:0] rdy;
   int           ptr, g, acc_cyc, clr, last_acc, resets, pick, k, txn, en_cnt;
   bit           busy, releasing, full;
   logic [15:0]  exp_a, exp_b;
   logic [2:0]   exp_op;
   logic [16:0]  exp_res;
   logic [N-1:0] exp_rdy;

   task automatic drive_main();
      bus.req_valid = pv;
      bus.rsp_ready = rdy;
      for (int i = 0; i < N; i++) begin
         bus.req_a[i*16 +: 16] = pa[i];
         bus.req_b[i*16 +: 16] = pb[i];
         bus.req_op[i*3 +: 3]  = po[i];
      end
   endtask

   initial begin
      rst = 1'b1;
      pv = '0; rdy = '0;
      for (int i = 0; i < N; i++) begin pa[i] = '0; pb[i] = '0; po[i] = '0; end
      drive_main();
      bus3.req_valid = '0; bus3.req_a = '0; bus3.req_b = '0; bus3.req_op = '0; bus3.rsp_ready = '0;
      repeat (2) @(negedge clk);
      check("rst_req_ready", 32'(bus.req_ready), 32'(0));
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
      check("rst_alu_en",    32'(bus.alu_Enable), 32'(0));
      check("rst_alu_a",     32'(bus.alu_A), 32'(0));
      check("rst_result",    32'(bus.rsp_result), 32'(0));
      rst = 1'b0;

      ptr = 0; busy = 0; releasing = 0; clr = -1; last_acc = -1; resets = 0; txn = 0;
      exp_a = '0; exp_b = '0; exp_op = '0; exp_res = '0; acc_cyc = 0; g = 0;
      // Directed seeds: ADD 5+3 on requester 0, carry-out ADD on requester 2
      pv[0] = 1'b1; pa[0] = 16'h0005; pb[0] = 16'h0003; po[0] = OP_ADD;
      pv[2] = 1'b1; pa[2] = 16'hFFFF; pb[2] = 16'h0001; po[2] = OP_ADD;

      for (int cyc = 1; cyc <= NCYC; cyc++) begin
         @(negedge clk);
         if (clr >= 0) begin pv[clr] = 1'b0; clr = -1; end
         if (releasing) begin
            busy = 0; releasing = 0; txn++;
            $display("txn %0d req=%0d a=%h b=%h op=%0d result=%h cout=%b",
                     txn, g, exp_a, exp_b, exp_op, exp_res[15:0], exp_res[16]);
         end
         k = cyc - acc_cyc;

         // Asynchronous reset mid-WAIT or mid-RESP
         if (busy && cyc > 50 && resets < 6 && (k == 1 || k >= L + 1) && $urandom_range(0, 7) == 0) begin
            rst = 1'b1;
            #1;
            busy = 0; ptr = 0; last_acc = -1; resets++;
            exp_a = '0; exp_b = '0; exp_op = '0;
            $display("reset applied at cycle %0d (k=%0d)", cyc, k);
            check("arst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
            check("arst_alu_en",    32'(bus.alu_Enable), 32'(0));
            check("arst_alu_a",     32'(bus.alu_A), 32'(0));
            check("arst_alu_b",     32'(bus.alu_B), 32'(0));
            check("arst_alu_op",    32'(bus.alu_opcode), 32'(0));
            check("arst_result",    32'(bus.rsp_result), 32'(0));
            check("arst_cout",      32'(bus.rsp_cout), 32'(0));
            pick = rr_pick(0, pv);
            check("arst_req_ready", 32'(bus.req_ready), (pick >= 0) ? (32'd1 << pick) : 32'd0);
            @(negedge clk);
            cyc++;
            rst = 1'b0;
         end

         k = cyc - acc_cyc;
         check("alu_a",   32'(bus.alu_A), 32'(exp_a));
         check("alu_b",   32'(bus.alu_B), 32'(exp_b));
         check("alu_op",  32'(bus.alu_opcode), 32'(exp_op));
         check("alu_en",  32'(bus.alu_Enable), 32'(busy && k == 0));
         check("rsp_valid", 32'(bus.rsp_valid), (busy && k >= L + 1) ? (32'd1 << g) : 32'd0);
         if (busy && k >= L + 1) begin
            check("rsp_result", 32'(bus.rsp_result), 32'(exp_res[15:0]));
            check("rsp_cout",   32'(bus.rsp_cout), 32'(exp_res[16]));
         end

         // New stimulus: cycles 1000..1999 keep every requester valid with XOR
         full = (cyc >= 1000 && cyc < 2000);
         for (int i = 0; i < N; i++) begin
            if (!pv[i] && cyc >= 5 && (full || $urandom_range(0, 2) == 0)) begin
               pv[i] = 1'b1;
               pa[i] = 16'($urandom);
               pb[i] = 16'($urandom);
               po[i] = full ? OP_XOR : 3'($urandom_range(0, 7));
            end
            rdy[i] = full ? 1'b1 : ($urandom_range(0, 2) == 0);
         end
         drive_main();
         #1;

         pick = busy ? -1 : rr_pick(ptr, pv);
         exp_rdy = (pick >= 0) ? (N'(1) << pick) : '0;
         check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
         if (pick >= 0) begin
            if (full && last_acc >= 1010)
               check("accept_gap", 32'(cyc + 1 - last_acc), 32'(L + 3));
            busy = 1; g = pick; acc_cyc = cyc + 1; last_acc = cyc + 1;
            exp_a = pa[g]; exp_b = pb[g]; exp_op = po[g];
            exp_res = alu_ref(pa[g], pb[g], po[g]);
            ptr = (g + 1) % N;
            clr = g;
         end else if (busy && k >= L + 1 && rdy[g]) begin
            releasing = 1;
         end
      end

      // Latency-3 instance: single SHL from requester 0
      @(negedge clk);
      bus3.req_valid = 4'b0001;
      bus3.req_a[15:0] = 16'h0001;
      bus3.req_b[15:0] = 16'h0000;
      bus3.req_op[2:0] = OP_SHL;
      bus3.rsp_ready = '0;
      #1;
      check("l3_req_ready", 32'(bus3.req_ready), 32'd1);
      en_cnt = 0;
      for (int j = 0; j <= 6; j++) begin
         @(negedge clk);
         if (j == 0) bus3.req_valid = '0;
         en_cnt += int'(bus3.alu_Enable);
         check("l3_rsp_valid", 32'(bus3.rsp_valid), 32'(j >= 4 && j <= 5));
         if (j >= 4 && j <= 5) begin
            check("l3_result", 32'(bus3.rsp_result), 32'h0002);
            check("l3_cout",   32'(bus3.rsp_cout), 32'd0);
         end
         if (j == 5) bus3.rsp_ready = 4'b0001;
      end
      check("l3_enable_cycles", 32'(en_cnt), 32'd1);
      #1;
      check("l3_idle_ready", 32'(bus3.req_ready), 32'd0);
      $display("txn l3 req=0 a=0001 op=SHL result=%h", bus3.rsp_result);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
